i2c_cmd_seq: RTL and testbench
==============================

# i2c_cmd_seq

Command sequencer sitting directly upstream of `i2c_master`. Buffers single-byte I2C commands (7-bit address, R/W, write byte) from a valid/ready host port, issues them one at a time to `i2c_master` via its `i2c_start`/`i2c_done` handshake, and returns read bytes through a buffered valid/ready result port. Adds a per-transaction timeout and a minimum idle gap between transactions.

## Interface
- `CMD_DEPTH`, 8: command FIFO entries (power of 2, ≥2)
- `RD_DEPTH`, 8: read-result FIFO entries (power of 2, ≥2)
- `GAP_CYC`, 4: minimum clk cycles from `i2c_done` to the next `i2c_start` (≥1)
- `TIMEOUT_CYC`, 4096: max clk cycles in WAIT_DONE before abort
- `clk` in 1: clock
- `arstn` in 1: reset, asynchronous, active-high
- `cmd_valid` in 1: host command valid
- `cmd_ready` out 1: `= !cmd_full`
- `cmd_addr` in 7: target address
- `cmd_rw` in 1: 0 write, 1 read
- `cmd_data` in 8: write byte (ignored for reads)
- `rd_valid` out 1: `= !rd_empty`
- `rd_ready` in 1: host pops read byte
- `rd_data` out 8: head of read FIFO (first-word fall-through)
- `busy` out 1: FSM not IDLE, or command FIFO not empty
- `timeout_err` out 1: sticky; cleared by `err_clr`
- `err_clr` in 1: one-cycle clear of `timeout_err`
- `i2c_start` out 1: one-cycle start pulse to `i2c_master`
- `addr` out 7, `rw` out 1, `data_send` out 8: registered; held stable from the start pulse until the next one
- `i2c_done` in 1: one-cycle pulse from master at transaction end
- `data_recv` in 8, `data_recv_done` in 1: read byte with one-cycle valid pulse

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE: when command FIFO non-empty AND (head `rw`=0 OR read FIFO not full) → pop head into `addr`/`rw`/`data_send`, go ISSUE. A read at the head with a full read FIFO stalls in IDLE; no reordering.
- ISSUE: `i2c_start`=1 for exactly this cycle; clear timeout counter; go WAIT_DONE.
- WAIT_DONE: if `rw`=1 and `data_recv_done`, push `data_recv` into read FIFO (at most one push per transaction; further pulses ignored). On `i2c_done` → GAP. If counter reaches `TIMEOUT_CYC-1` without `i2c_done` → set `timeout_err`, no push, go GAP.
- `i2c_done` and `data_recv_done` in the same cycle: both honoured (push, then GAP).
- GAP: count `GAP_CYC` cycles, then IDLE.
- `data_recv_done`/`i2c_done` outside WAIT_DONE: ignored.
- Command FIFO: push on `cmd_valid && cmd_ready`; push and pop in the same cycle are legal when not full. Read FIFO: pop on `rd_valid && rd_ready`; simultaneous push/pop legal.
- `err_clr` and a timeout in the same cycle: set wins.
- Reset (any time, mid-transaction included): FIFOs emptied, FSM → IDLE, in-flight command dropped.

## Timing
- Reset values: `cmd_ready`=1, `rd_valid`=0, `rd_data`=0, `busy`=0, `timeout_err`=0, `i2c_start`=0, `addr`=0, `rw`=0, `data_send`=0.
- Latency: command accepted at edge N into an empty FIFO with FSM in IDLE → `i2c_start` high in cycle N+2.
- Back-to-back: `i2c_done` in cycle D → next `i2c_start` no earlier than cycle D+GAP_CYC+2.
- Read byte pushed at edge R → `rd_valid` high in cycle R+1.
- Timeout fires exactly `TIMEOUT_CYC` cycles after the ISSUE cycle.

## Structure
- `i2c_pkg`: FSM state enum, `I2C_ADDR_W`=7, `I2C_DATA_W`=8, command word width (16 = {rw, addr, data}).
- One sub-module, `sync_fifo` (parameterised width/depth, FWFT, full/empty), instantiated twice: command (16 bits) and read (8 bits).

## Test plan
- Single write {addr 7'h25, rw 0, data 8'h63}: `i2c_start` pulse at N+2 with `addr`=25h, `data_send`=63h; `i2c_done` returned → `busy` falls after GAP; `rd_valid` stays 0.
- Write 25h/63h, then read 4Ch, back-to-back; master returns 8'h33: two start pulses ≥GAP_CYC+2 cycles apart; `rd_data`=33h, one entry.
- Fill CMD_DEPTH+1 commands with the master stalled: `cmd_ready`=0 after 8 accepted (plus 1 in flight); order preserved at `i2c_start`.
- RD_DEPTH+1 reads, `rd_ready`=0: ninth read stalls in IDLE; one pop → ninth issues; data order intact.
- Master never returns `i2c_done`: `timeout_err`=1 after exactly TIMEOUT_CYC cycles; next command issues; `err_clr` clears.
- Assert `arstn` during WAIT_DONE: all outputs at reset values, FIFOs empty, later `i2c_done` ignored.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared widths, FSM states and command word layout for the I2C command sequencer.
package i2c_pkg;
    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;
    localparam int CMD_W      = 1 + I2C_ADDR_W + I2C_DATA_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} seq_state_e;

    typedef struct packed {
        logic                  rw;
        logic [I2C_ADDR_W-1:0] addr;
        logic [I2C_DATA_W-1:0] data;
    } cmd_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; head reads as zero while empty.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         arstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wp_q, wp_d, rp_q, rp_d;
    logic         do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = wp_q == rp_q;
    assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem_q[rp_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wp_q[AW-1:0]] = din;
        wp_d = wp_q + {{AW{1'b0}}, do_push};
        rp_d = rp_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq: buffers host I2C commands, issues them one at a time to i2c_master
// with a per-transaction timeout and a minimum idle gap, and queues read bytes.
module i2c_cmd_seq
    import i2c_pkg::*;
#(
    parameter int CMD_DEPTH   = 8,
    parameter int RD_DEPTH    = 8,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [I2C_ADDR_W-1:0] cmd_addr,
    input  logic                  cmd_rw,
    input  logic [I2C_DATA_W-1:0] cmd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [I2C_DATA_W-1:0] rd_data,
    output logic                  busy,
    output logic                  timeout_err,
    input  logic                  err_clr,
    output logic                  i2c_start,
    output logic [I2C_ADDR_W-1:0] addr,
    output logic                  rw,
    output logic [I2C_DATA_W-1:0] data_send,
    input  logic                  i2c_done,
    input  logic [I2C_DATA_W-1:0] data_recv,
    input  logic                  data_recv_done
);
    localparam int            CNT_MAX  = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int            CW       = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    cmd_t          cur_q, cur_d, cmd_head;
    logic          got_q, got_d, err_q, err_d;
    logic          cmd_full, cmd_empty, cmd_pop;
    logic          rd_full, rd_empty, rd_push, timeout;

    sync_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .arstn (arstn),
        .push  (cmd_valid && cmd_ready),
        .din   ({cmd_rw, cmd_addr, cmd_data}),
        .pop   (cmd_pop),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    sync_fifo #(.W(I2C_DATA_W), .DEPTH(RD_DEPTH)) u_rd_fifo (
        .clk   (clk),
        .arstn (arstn),
        .push  (rd_push),
        .din   (data_recv),
        .pop   (rd_valid && rd_ready),
        .dout  (rd_data),
        .full  (rd_full),
        .empty (rd_empty)
    );

    assign cmd_ready   = !cmd_full;
    assign rd_valid    = !rd_empty;
    assign busy        = (state_q != IDLE) || !cmd_empty;
    assign timeout_err = err_q;
    assign i2c_start   = state_q == ISSUE;
    assign addr        = cur_q.addr;
    assign rw          = cur_q.rw;
    assign data_send   = cur_q.data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        cur_d   = cur_q;
        got_d   = got_q;
        err_d   = err_q && !err_clr;
        cmd_pop = 1'b0;
        rd_push = 1'b0;
        timeout = 1'b0;
        case (state_q)
            // A read waits for read-FIFO room before leaving the queue, so its byte always fits.
            IDLE: if (!cmd_empty && (!cmd_head.rw || !rd_full)) begin
                cmd_pop = 1'b1;
                cur_d   = cmd_head;
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                got_d   = 1'b0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                timeout = !i2c_done && (cnt_q == TO_LAST);
                rd_push = cur_q.rw && data_recv_done && !got_q && !timeout;
                if (rd_push) got_d = 1'b1;
                if (timeout) err_d = 1'b1;
                if (i2c_done || timeout) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: if (cnt_q == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cur_q   <= '0;
            got_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            got_q   <= got_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_i2c_cmd_seq.sv
// tb_i2c_cmd_seq: directed and randomized bench for i2c_cmd_seq against a host/master
// behavioural model (expected command order, returned read bytes, cycle-accurate timing rules).
module tb_i2c_cmd_seq;
    localparam int CMD_DEPTH = 8;
    localparam int RD_DEPTH  = 8;
    localparam int GAP       = 4;
    localparam int TO        = 64;

    logic       clk = 1'b0, arstn = 1'b1;
    logic       cmd_valid = 1'b0, cmd_rw = 1'b0, rd_ready = 1'b0, err_clr = 1'b0;
    logic       i2c_done = 1'b0, data_recv_done = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0, data_recv = '0;
    logic       cmd_ready, rd_valid, busy, timeout_err, i2c_start, rw;
    logic [7:0] rd_data, data_send;
    logic [6:0] addr;

    i2c_cmd_seq #(
        .CMD_DEPTH(CMD_DEPTH), .RD_DEPTH(RD_DEPTH), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .arstn(arstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_data(cmd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr),
        .i2c_start(i2c_start), .addr(addr), .rw(rw), .data_send(data_send),
        .i2c_done(i2c_done), .data_recv(data_recv), .data_recv_done(data_recv_done)
    );

    always #5 clk = ~clk;

    int         n_chk = 0, n_fail = 0, cyc = 0, starts = 0, start_cyc = 0, done_cyc = 0;
    int         cd = 0, elapsed = 0, rcv_at = 0, inj = 0, inj_seen = 0;
    bit         have_done = 1'b0, stall = 1'b0, cur_rd = 1'b0, acc = 1'b0;
    logic [8:0] fixed_rb = '0;
    logic [7:0] rb = '0;
    logic [15:0] exp_cmd[$];
    logic [7:0]  exp_rd[$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Master model: answers each start after a random delay, returns one read byte
    // (plus a stray second pulse that must be ignored), or stays silent when stalled.
    task automatic master_step();
        i2c_done       = 1'b0;
        data_recv_done = 1'b0;
        if (inj != inj_seen) begin
            inj_seen       = inj;
            i2c_done       = 1'b1;
            data_recv_done = 1'b1;
            data_recv      = 8'hEE;
        end
        if (i2c_start) begin
            starts++;
            start_cyc = cyc;
            cur_rd    = rw;
            if (exp_cmd.size() == 0) check("start_unexpected", 1, 0);
            else check("cmd_order", {rw, addr, data_send}, exp_cmd.pop_front());
            if (have_done) check("gap_min", (cyc - done_cyc) >= GAP + 2, 1);
            cd      = stall ? 0 : int'($urandom_range(6, 1));
            rcv_at  = int'($urandom_range(cd, 1));
            rb      = fixed_rb[8] ? fixed_rb[7:0] : 8'($urandom);
            elapsed = 0;
        end else if (cd > 0) begin
            elapsed++;
            if (cur_rd && elapsed == rcv_at) begin
                data_recv_done = 1'b1;
                data_recv      = rb;
                exp_rd.push_back(rb);
            end
            if (cur_rd && elapsed == rcv_at + 1) begin
                data_recv_done = 1'b1;
                data_recv      = ~rb;
            end
            if (elapsed == cd) begin
                i2c_done  = 1'b1;
                done_cyc  = cyc;
                have_done = 1'b1;
                cd        = 0;
            end
        end
    endtask

    // Commit this cycle's host handshakes, advance to the next mid-cycle point, then model the master.
    task automatic tick();
        acc = cmd_valid && cmd_ready;
        if (acc) exp_cmd.push_back({cmd_rw, cmd_addr, cmd_data});
        if (rd_valid && rd_ready) begin
            if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
            else check("rd_data", rd_data, exp_rd.pop_front());
        end
        @(negedge clk);
        cyc++;
        check("rd_valid", rd_valid, exp_rd.size() != 0);
        master_step();
    endtask

    task automatic send(bit r, logic [6:0] a, logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_rw    = r;
        cmd_addr  = a;
        cmd_data  = d;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (acc) break;
        end
        check("send_accepted", acc, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_starts(int target, int budget, string tag);
        for (int i = 0; i < budget && starts < target; i++) tick();
        check(tag, starts >= target, 1);
    endtask

    task automatic wait_idle(int budget, string tag);
        for (int i = 0; i < budget && busy; i++) tick();
        check(tag, busy, 0);
    endtask

    task automatic check_reset(string t);
        check({t, "_cmd_ready"}, cmd_ready, 1);
        check({t, "_rd_valid"}, rd_valid, 0);
        check({t, "_rd_data"}, rd_data, 0);
        check({t, "_busy"}, busy, 0);
        check({t, "_timeout_err"}, timeout_err, 0);
        check({t, "_i2c_start"}, i2c_start, 0);
        check({t, "_addr"}, addr, 0);
        check({t, "_rw"}, rw, 0);
        check({t, "_data_send"}, data_send, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, b, k, s0;
        repeat (3) tick();
        check_reset("reset");
        arstn = 1'b0;
        tick();

        // Single write: start two cycles after acceptance, busy falls GAP+1 cycles after done.
        n = cyc;
        b = starts;
        send(1'b0, 7'h25, 8'h63);
        wait_starts(b + 1, 20, "t1_start_seen");
        check("t1_latency", start_cyc - n, 2);
        check("t1_addr", addr, 7'h25);
        check("t1_data_send", data_send, 8'h63);
        check("t1_rw", rw, 0);
        wait_idle(50, "t1_idle");
        check("t1_busy_fall", cyc - done_cyc, GAP + 1);
        check("t1_no_rd", rd_valid, 0);

        // Write then read back-to-back; master returns 33h.
        fixed_rb = 9'h133;
        b = starts;
        send(1'b0, 7'h25, 8'h63);
        send(1'b1, 7'h4C, 8'h00);
        wait_starts(b + 2, 50, "t2_starts_seen");
        check("t2_gap_exact", start_cyc - done_cyc, GAP + 2);
        check("t2_rd_addr", addr, 7'h4C);
        for (int i = 0; i < 50 && !rd_valid; i++) tick();
        check("t2_rd_byte", rd_data, 8'h33);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("t2_one_entry", rd_valid, 0);
        fixed_rb = '0;
        wait_idle(50, "t2_idle");

        // Fill the command FIFO while the master is silent, then watch the first one time out.
        stall = 1'b1;
        b = starts;
        k = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 40 && cmd_ready; i++) begin
            cmd_rw   = 1'b0;
            cmd_addr = 7'(i + 1);
            cmd_data = 8'($urandom);
            tick();
            if (acc) k++;
        end
        cmd_valid = 1'b0;
        check("t3_accepted", k, CMD_DEPTH + 1);
        check("t3_full", cmd_ready, 0);
        check("t3_busy", busy, 1);
        check("t3_one_issued", starts, b + 1);
        s0 = start_cyc;
        while (cyc < s0 + TO) tick();
        check("t4_err_not_yet", timeout_err, 0);
        stall = 1'b0;
        tick();
        check("t4_err_set", timeout_err, 1);
        wait_starts(b + 2, GAP + 10, "t4_next_seen");
        check("t4_next_issue", start_cyc - s0, TO + GAP + 2);
        check("t4_err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_err_clr", timeout_err, 0);
        wait_idle(400, "t3_drained");

        // Read FIFO full: the ninth read must wait in IDLE until one byte is popped.
        b = starts;
        rd_ready = 1'b0;
        for (int i = 0; i < RD_DEPTH + 1; i++) send(1'b1, 7'(8'h40 + i), 8'h00);
        wait_starts(b + RD_DEPTH, 300, "t5_eight_seen");
        repeat (40) tick();
        check("t5_stalled", starts, b + RD_DEPTH);
        check("t5_rd_valid", rd_valid, 1);
        check("t5_busy", busy, 1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        wait_starts(b + RD_DEPTH + 1, 20, "t5_ninth_issued");
        rd_ready = 1'b1;
        wait_idle(100, "t5_idle");
        for (int i = 0; i < 40 && rd_valid; i++) tick();
        check("t5_drained", exp_rd.size(), 0);
        rd_ready = 1'b0;

        // Reset during WAIT_DONE with more commands queued; late master pulses are ignored.
        stall = 1'b1;
        b = starts;
        send(1'b1, 7'h11, 8'h00);
        send(1'b0, 7'h12, 8'h5A);
        send(1'b0, 7'h13, 8'hA5);
        wait_starts(b + 1, 20, "t6_start_seen");
        repeat (3) tick();
        arstn = 1'b1;
        exp_cmd.delete();
        exp_rd.delete();
        cd = 0;
        have_done = 1'b0;
        tick();
        check_reset("t6_reset");
        arstn = 1'b0;
        stall = 1'b0;
        inj++;
        repeat (12) tick();
        check("t6_no_start", starts, b + 1);
        check("t6_busy", busy, 0);
        check("t6_cmd_ready", cmd_ready, 1);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            cmd_valid = ($urandom_range(2, 0) == 0);
            cmd_rw    = 1'($urandom);
            cmd_addr  = 7'($urandom);
            cmd_data  = 8'($urandom);
            rd_ready  = 1'($urandom);
            tick();
        end
        cmd_valid = 1'b0;
        rd_ready  = 1'b1;
        for (int i = 0; i < 3000 && (busy || rd_valid); i++) tick();
        check("rand_drained", busy || rd_valid, 0);
        check("rand_cmds_issued", exp_cmd.size(), 0);
        check("rand_no_timeout", timeout_err, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
